// File: rtl/ava_pkg.sv
// Shared types and constants for the vector issue-control slice: element-width
// and sequencer-state enums plus the register-group address step helper.
package ava_pkg;

  localparam int VLEN   = 32;
  localparam int NUM_PE = 4;
  localparam int VL_W   = 6;
  localparam int REG_AW = $clog2(VLEN);

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } seq_state_t;

  // Register-group stride: one register per group at 8b, doubling per width step.
  function automatic logic [REG_AW-1:0] addr_step(input logic [1:0] sew, input logic widen);
    return REG_AW'(1) << (3'(sew) + 3'(widen));
  endfunction

endpackage

// File: rtl/vseq_addr_gen.sv
// Register-file address generator: loads the three base registers on accept and
// advances them by the element-width stride after each non-final write-back.
module vseq_addr_gen
  import ava_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [4:0]        vs1_base_i,
  input  logic [4:0]        vs2_base_i,
  input  logic [4:0]        vd_base_i,
  input  logic [1:0]        sew_i,
  input  logic              widen_i,
  output logic [4:0]        vs1_addr_o,
  output logic [4:0]        vs2_addr_o,
  output logic [4:0]        vd_addr_o
);

  logic [REG_AW-1:0] vs_step;
  logic [REG_AW-1:0] vd_step;
  logic [4:0]        vs1_q, vs2_q, vd_q;

  assign vs_step = addr_step(sew_i, 1'b0);
  assign vd_step = addr_step(sew_i, widen_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vs1_q <= '0;
      vs2_q <= '0;
      vd_q  <= '0;
    end else if (load_i) begin
      vs1_q <= vs1_base_i;
      vs2_q <= vs2_base_i;
      vd_q  <= vd_base_i;
    end else if (step_i) begin
      vs1_q <= vs1_q + vs_step;
      vs2_q <= vs2_q + vs_step;
      vd_q  <= vd_q + vd_step;
    end
  end

  assign vs1_addr_o = vs1_q;
  assign vs2_addr_o = vs2_q;
  assign vd_addr_o  = vd_q;

endmodule

// File: rtl/vector_element_sequencer.sv
// Walks one vector instruction's elements in groups of four: issue, PE wait, write-back.
// Optional AVA_SEQ_PERF_CNT_EN adds busy-cycle and group performance counters.
module vector_element_sequencer
  import ava_pkg::*;
#(
  parameter int PE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  vs1_base,
  input  logic [4:0]  vs2_base,
  input  logic [4:0]  vd_base,
  input  logic [1:0]  vsew_in,
  input  logic [5:0]  vl_in,
  input  logic        widening_in,
  output logic [4:0]  vs1_addr,
  output logic [4:0]  vs2_addr,
  output logic [4:0]  vd_addr,
  output logic [1:0]  vsew,
  output logic        widening_op,
  output logic [1:0]  elements_to_write,
  output logic        write,
  output logic        pe_start,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef AVA_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_groups
`endif
);

  localparam logic [2:0] WAIT_LOAD = 3'(PE_LATENCY - 1);

  seq_state_t        state_q, state_d;
  logic [VL_W-1:0]   remaining_q, remaining_d;
  logic [2:0]        wait_q, wait_d;
  sew_t              vsew_q;
  logic              widen_q;
  logic              done_q, err_q;
  logic              accept, illegal, no_work, step, last_write;

  assign accept  = instr_valid && (state_q == S_IDLE);
  assign illegal = widening_in && (vsew_in == SEW32);
  assign no_work = (vl_in == '0) || illegal;

  // NOTE: every variable written here is defaulted first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    step        = 1'b0;
    last_write  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          remaining_d = vl_in;
          if (!no_work) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = (PE_LATENCY == 1) ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q <= 3'd1) state_d = S_WRITE;
        else                wait_d  = wait_q - 3'd1;
      end
      S_WRITE: begin
        if (remaining_q > VL_W'(NUM_PE)) begin
          remaining_d = remaining_q - VL_W'(NUM_PE);
          step        = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          remaining_d = '0;
          last_write  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      vsew_q      <= SEW8;
      widen_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      done_q      <= accept && no_work;
      err_q       <= accept && illegal;
      if (accept) begin
        vsew_q  <= sew_t'(vsew_in);
        widen_q <= widening_in;
      end
    end
  end

  vseq_addr_gen u_addr_gen (
    .clk        (clk),
    .n_reset    (n_reset),
    .load_i     (accept),
    .step_i     (step),
    .vs1_base_i (vs1_base),
    .vs2_base_i (vs2_base),
    .vd_base_i  (vd_base),
    .sew_i      (vsew_q),
    .widen_i    (widen_q),
    .vs1_addr_o (vs1_addr),
    .vs2_addr_o (vs2_addr),
    .vd_addr_o  (vd_addr)
  );

  assign instr_ready       = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign pe_start          = (state_q == S_ISSUE);
  assign write             = (state_q == S_WRITE);
  assign done              = done_q || last_write;
  assign err               = err_q;
  assign vsew              = vsew_q;
  assign widening_op       = widen_q;
  // A full group is encoded as 0 so the field fits in two bits.
  assign elements_to_write = (remaining_q >= VL_W'(NUM_PE)) ? 2'd0 : remaining_q[1:0];

`ifdef AVA_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_groups_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      perf_busy_q   <= '0;
      perf_groups_q <= '0;
    end else begin
      if (busy)  perf_busy_q   <= perf_busy_q + 32'd1;
      if (write) perf_groups_q <= perf_groups_q + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_groups      = perf_groups_q;
`endif

endmodule
